sram_like_bridge: RTL and testbench

Parametrised bridge converting a core's split request/response memory handshake (req / addr_ok / data_ok) into a plain synchronous SRAM port with one-cycle read latency. It holds up to DEPTH outstanding transactions, returns responses in order with a programmable fixed latency, and discards in-flight responses on a pipeline flush. One instance sits between the fetch stage and inst SRAM and another between the execute/memory stages and data SRAM. This replaces the direct en/we/addr/wdata/rdata wiring used in the current top level.

---
 rtl/sram_like_bridge.sv | 117 +++++++++++
 tb/tb_sram_like_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_bridge.sv
// Bridges the core's split req/addr_ok/data_ok handshake onto a plain SRAM port with
// one-cycle read latency; up to DEPTH in-order transactions, responses droppable by flush.
module sram_like_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req,
    input  logic                wr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                flush,
    output logic                addr_ok,
    output logic                data_ok,
    output logic [DATA_W-1:0]   rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(LATENCY + 1);
    localparam int NW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  ent_vld;
    logic [DEPTH-1:0]  ent_wr;
    logic [DEPTH-1:0]  ent_dis;
    logic [DEPTH-1:0]  ent_cap;
    logic [CW-1:0]     ent_cnt  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [NW-1:0]     count;

    logic              cap_vld_p1;
    logic [PW-1:0]     cap_idx_p1;

    logic              accept;
    logic              head_cap;
    logic              retire;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] head_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Stage p0: request acceptance drives the SRAM in the same cycle
    always_comb begin
        accept     = resetn && req && !flush && (count < NW'(DEPTH));
        cap_data   = ent_wr[cap_idx_p1] ? '0 : sram_rdata;
        head_cap   = ent_cap[head] || (cap_vld_p1 && (cap_idx_p1 == head));
        retire     = ent_vld[head] && (ent_cnt[head] == '0) && head_cap;
        // An uncaptured head can only be the entry whose SRAM data is arriving right now
        head_data  = ent_cap[head] ? ent_data[head] : cap_data;
        data_ok    = retire && !ent_dis[head] && !flush;
        rdata      = data_ok ? head_data : '0;
        addr_ok    = accept;
        sram_en    = accept;
        sram_we    = (accept && wr) ? wstrb : '0;
        sram_addr  = accept ? addr : '0;
        sram_wdata = accept ? wdata : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_vld    <= '0;
            ent_wr     <= '0;
            ent_dis    <= '0;
            ent_cap    <= '0;
            for (int i = 0; i < DEPTH; i++) ent_cnt[i] <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            cap_vld_p1 <= 1'b0;
            cap_idx_p1 <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld[i] && (ent_cnt[i] != '0)) ent_cnt[i] <= ent_cnt[i] - CW'(1);
                if (flush && ent_vld[i]) ent_dis[i] <= 1'b1;
            end
            if (cap_vld_p1) ent_cap[cap_idx_p1] <= 1'b1;
            if (retire) begin
                ent_vld[head] <= 1'b0;
                head          <= ptr_inc(head);
            end
            if (accept) begin
                ent_vld[tail] <= 1'b1;
                ent_wr[tail]  <= wr;
                ent_dis[tail] <= 1'b0;
                ent_cap[tail] <= 1'b0;
                ent_cnt[tail] <= CW'(LATENCY - 1);
                tail          <= ptr_inc(tail);
            end
            case ({accept, retire})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            cap_vld_p1 <= accept;
            cap_idx_p1 <= tail;
        end
    end

    // Stage p1: SRAM read data (or zero for a write) lands in the entry accepted last cycle
    always_ff @(posedge clk) begin
        if (cap_vld_p1) ent_data[cap_idx_p1] <= cap_data;
    end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Scoreboard bench for sram_like_bridge: four instances with different DEPTH/LATENCY,
// each backed by a small behavioural SRAM.
module tb_sram_like_bridge;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn     [4];
    logic        req        [4];
    logic        wr         [4];
    logic [3:0]  wstrb      [4];
    logic [31:0] addr       [4];
    logic [31:0] wdata      [4];
    logic        flush      [4];
    logic        addr_ok    [4];
    logic        data_ok    [4];
    logic [31:0] rdata      [4];
    logic        sram_en    [4];
    logic [3:0]  sram_we    [4];
    logic [31:0] sram_addr  [4];
    logic [31:0] sram_wdata [4];
    logic [31:0] sram_rdata [4];

    logic [31:0] mem [4][128];
    logic        init_mem = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          done = 1'b0;
    exp_t        exp_q [4][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sram_like_bridge #(
            .ADDR_W (32),
            .DATA_W (32),
            .DEPTH  ((g == 2) ? 2 : 4),
            .LATENCY((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 2)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn[g]),
            .req       (req[g]),
            .wr        (wr[g]),
            .wstrb     (wstrb[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .flush     (flush[g]),
            .addr_ok   (addr_ok[g]),
            .data_ok   (data_ok[g]),
            .rdata     (rdata[g]),
            .sram_en   (sram_en[g]),
            .sram_we   (sram_we[g]),
            .sram_addr (sram_addr[g]),
            .sram_wdata(sram_wdata[g]),
            .sram_rdata(sram_rdata[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 2;
    endfunction

    function automatic logic [31:0] init_word(input int g, input int i);
        if (g == 0 && i == 64) return 32'hDEAD_BEEF;
        if (g == 3 && i == 16) return 32'hFFFF_FFFF;
        return 32'hA500_0000 | (32'(g) << 16) | 32'(i);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: read-first, one-cycle read latency, byte write enables
    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (init_mem) begin
                sram_rdata[g] <= '0;
                for (int i = 0; i < 128; i++) mem[g][i] <= init_word(g, i);
            end else if (sram_en[g]) begin
                sram_rdata[g] <= mem[g][sram_addr[g][8:2]];
                for (int b = 0; b < 4; b++)
                    if (sram_we[g][b])
                        mem[g][sram_addr[g][8:2]][b*8 +: 8] <= sram_wdata[g][b*8 +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req_v);
        end
    endtask

    task automatic check_quiet(input int g, input string tag);
        check($sformatf("%s i%0d addr_ok", tag, g), 32'(addr_ok[g]), 32'd0);
        check($sformatf("%s i%0d data_ok", tag, g), 32'(data_ok[g]), 32'd0);
        check($sformatf("%s i%0d sram_en", tag, g), 32'(sram_en[g]), 32'd0);
        check($sformatf("%s i%0d sram_we", tag, g), 32'(sram_we[g]), 32'd0);
        check($sformatf("%s i%0d rdata", tag, g), rdata[g], 32'd0);
        check($sformatf("%s i%0d sram_addr", tag, g), sram_addr[g], 32'd0);
        check($sformatf("%s i%0d sram_wdata", tag, g), sram_wdata[g], 32'd0);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic want, input logic [31:0] exp_d);
        exp_t e;
        req[g] = 1'b1; wr[g] = w; addr[g] = a; wdata[g] = d; wstrb[g] = s;
        @(negedge clk);
        check($sformatf("addr_ok i%0d a=%h", g, a), 32'(addr_ok[g]), 32'd1);
        check($sformatf("sram_en i%0d a=%h", g, a), 32'(sram_en[g]), 32'd1);
        check($sformatf("sram_addr i%0d", g), sram_addr[g], a);
        check($sformatf("sram_we i%0d a=%h", g, a), 32'(sram_we[g]), w ? 32'(s) : 32'd0);
        if (addr_ok[g] && want) begin
            e.data = exp_d;
            e.due  = cyc + lat_of(g);
            exp_q[g].push_back(e);
        end
        @(posedge clk); #1;
        req[g] = 1'b0; wr[g] = 1'b0; wstrb[g] = '0;
    endtask

    task automatic monitor_loop();
        exp_t e;
        while (!done) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (data_ok[g]) begin
                    n_cmp++;
                    if (exp_q[g].size() == 0) begin
                        n_bad++;
                        $display("FAIL stray_data_ok i%0d cyc=%0d: got data_ok=1 rdata=%h, required no response",
                                 g, cyc, rdata[g]);
                    end else begin
                        e = exp_q[g].pop_front();
                        if (rdata[g] !== e.data || cyc != e.due) begin
                            n_bad++;
                            $display("FAIL resp i%0d: got rdata=%h at cyc %0d, required %h at cyc %0d",
                                     g, rdata[g], cyc, e.data, e.due);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic stimulus();
        logic [31:0] b2b_exp [4];
        logic [7:0]  full_pat;
        logic [31:0] a;
        int          acc;
        exp_t        e;
        b2b_exp  = '{32'hA501_0000, 32'hA501_0001, 32'hA501_0002, 32'hA501_0003};
        full_pat = 8'b0110_0011;  // bit k = expected addr_ok in stall cycle k

        // Reset state, with req asserted to confirm nothing is accepted
        for (int g = 0; g < 4; g++) begin
            resetn[g] = 1'b0; req[g] = 1'b1; wr[g] = 1'b1; wstrb[g] = 4'hF;
            addr[g] = 32'h1234; wdata[g] = 32'h5555_AAAA; flush[g] = 1'b0;
        end
        @(posedge clk); #1;
        init_mem = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 4; g++) check_quiet(g, "reset");
        @(posedge clk); #1;
        for (int g = 0; g < 4; g++) begin
            req[g] = 1'b0; wr[g] = 1'b0; wstrb[g] = '0; resetn[g] = 1'b1;
        end

        // Single read on the first edge after reset release, LATENCY=1
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);
        wait_cycles(3);

        // Back-to-back reads, LATENCY=3
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b1, b2b_exp[i]);
        wait_cycles(6);

        // Flush one cycle after three accepted reads; request during flush must be refused
        for (int i = 0; i < 3; i++) issue(1, 1'b0, 32'h20 + 32'(4 * i), 32'h0, 4'h0, 1'b0, 32'h0);
        flush[1] = 1'b1; req[1] = 1'b1; addr[1] = 32'h30;
        @(negedge clk);
        check("flush addr_ok", 32'(addr_ok[1]), 32'd0);
        check("flush sram_en", 32'(sram_en[1]), 32'd0);
        @(posedge clk); #1;
        flush[1] = 1'b0; req[1] = 1'b0;
        wait_cycles(5);
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hA501_0004);
        wait_cycles(5);
        check("flush count drained", 32'(g_dut[1].u_dut.count), 32'd0);

        // Full stall: DEPTH=2, LATENCY=4, req held high
        acc = 0;
        a = 32'h20;
        req[2] = 1'b1; addr[2] = a;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("full addr_ok k=%0d", k), 32'(addr_ok[2]), 32'(full_pat[k]));
            if (addr_ok[2]) begin
                e.data = 32'hA502_0008 + 32'(acc);
                e.due  = cyc + 4;
                exp_q[2].push_back(e);
            end
            @(posedge clk); #1;
            if (e.due == cyc + 3 && acc < 8) begin
                acc++;
                a = a + 32'd4;
                addr[2] = a;
            end
        end
        req[2] = 1'b0;
        wait_cycles(10);

        // Partial-strobe write then read-back, LATENCY=2
        issue(3, 1'b1, 32'h40, 32'h1234_5678, 4'b0011, 1'b1, 32'h0);
        issue(3, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'hFFFF_5678);
        wait_cycles(4);

        // Asynchronous reset with two reads outstanding
        issue(3, 1'b0, 32'h48, 32'h0, 4'h0, 1'b0, 32'h0);
        issue(3, 1'b0, 32'h4C, 32'h0, 4'h0, 1'b0, 32'h0);
        req[3] = 1'b1; addr[3] = 32'h50;
        #2;
        resetn[3] = 1'b0;
        #1;
        check_quiet(3, "async_reset");
        @(posedge clk); #4;
        req[3] = 1'b0;
        resetn[3] = 1'b1;
        wait_cycles(6);
        issue(3, 1'b0, 32'h44, 32'h0, 4'h0, 1'b1, 32'hA503_0011);
        wait_cycles(5);
        done = 1'b1;
    endtask

    initial begin
        fork
            monitor_loop();
            stimulus();
        join
        for (int g = 0; g < 4; g++)
            check($sformatf("drained i%0d", g), 32'(exp_q[g].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
